alu16_nibble_sequencer: RTL and testbench

- Initiator side of the 4-bit ALU slice interface.
- Accepts 16-bit operations over a valid/ready request channel and issues them to one external 4-bit ALU slice as four sequential nibble operations, LSB nibble first, chaining carry between nibbles.
- Returns the assembled 16-bit result plus flags over a valid/ready response channel.
- Gives the 16-bit ALU datapath a one-slice, area-minimal implementation.

---
 rtl/alu16_pkg.sv | 23 ++
 rtl/alu16_nibble_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_alu16_nibble_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu16_pkg.sv
// Shared definitions for the nibble-serial 16-bit ALU sequencer: opcodes, FSM states, slice width.
package alu16_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Add and subtract are the only opcodes that chain carry between nibbles.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu16_nibble_sequencer.sv
// Issues one 16-bit op to an external 4-bit ALU slice as LSB-first nibbles with carry chaining.
// Optional rsp_ovf output is enabled by defining ALU16_OVERFLOW_FLAG_EN.
module alu16_nibble_sequencer
    import alu16_pkg::*;
#(
    parameter int   NIBBLES  = 4,
    parameter logic SUB_CIN0 = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_b,
    input  logic [2:0]                   req_opcode,
    output logic [NIBBLE_W-1:0]          slice_a,
    output logic [NIBBLE_W-1:0]          slice_b,
    output logic [2:0]                   slice_opcode,
    output logic                         slice_c_in,
    input  logic [NIBBLE_W-1:0]          slice_result,
    input  logic                         slice_c_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_result,
    output logic                         rsp_c_out,
    output logic                         rsp_zero,
    output logic                         rsp_err
`ifdef ALU16_OVERFLOW_FLAG_EN
    ,
    output logic                         rsp_ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [W-1:0]        a_r, a_s, b_r, b_s;
    logic [2:0]          op_r, op_s;
    logic [W-1:0]        result_r, result_s, merged_s;
    logic [NIBBLE_W-1:0] slice_a_r, slice_a_s, slice_b_r, slice_b_s;
    logic [2:0]          slice_op_r, slice_op_s;
    logic                slice_cin_r, slice_cin_s;
    logic                req_ready_r, req_ready_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [W-1:0]        rsp_result_r, rsp_result_s;
    logic                rsp_c_out_r, rsp_c_out_s;
    logic                rsp_zero_r, rsp_zero_s;
    logic                rsp_err_r, rsp_err_s;
    logic                drv_en_s, drv_cin_s;
    logic [W-1:0]        drv_a_s, drv_b_s;
    logic [2:0]          drv_op_s;
    logic [IDX_W-1:0]    drv_idx_s;
`ifdef ALU16_OVERFLOW_FLAG_EN
    logic                rsp_ovf_r, rsp_ovf_s;
`endif

    // Next-state, datapath and next slice-drive computation; slice drive is registered one cycle ahead.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        a_s          = a_r;
        b_s          = b_r;
        op_s         = op_r;
        result_s     = result_r;
        rsp_result_s = rsp_result_r;
        rsp_c_out_s  = rsp_c_out_r;
        rsp_zero_s   = rsp_zero_r;
        rsp_err_s    = rsp_err_r;
`ifdef ALU16_OVERFLOW_FLAG_EN
        rsp_ovf_s    = rsp_ovf_r;
`endif
        drv_en_s     = 1'b0;
        drv_a_s      = a_r;
        drv_b_s      = b_r;
        drv_op_s     = op_r;
        drv_idx_s    = idx_r;
        drv_cin_s    = 1'b0;
        merged_s     = result_r;
        merged_s[NIBBLE_W*idx_r +: NIBBLE_W] = (op_r == OP_ILLEGAL) ? {NIBBLE_W{1'b0}} : slice_result;

        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    a_s       = req_a;
                    b_s       = req_b;
                    op_s      = req_opcode;
                    idx_s     = {IDX_W{1'b0}};
                    result_s  = {W{1'b0}};
                    state_s   = RUN;
                    drv_en_s  = 1'b1;
                    drv_a_s   = req_a;
                    drv_b_s   = req_b;
                    drv_op_s  = req_opcode;
                    drv_idx_s = {IDX_W{1'b0}};
                    drv_cin_s = (req_opcode == OP_SUB) ? SUB_CIN0 : 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                result_s = merged_s;
                if (idx_r == LAST_IDX) begin
                    state_s      = DONE;
                    rsp_result_s = merged_s;
                    rsp_c_out_s  = is_arith(op_r) ? slice_c_out : 1'b0;
                    rsp_zero_s   = (merged_s == {W{1'b0}});
                    rsp_err_s    = (op_r == OP_ILLEGAL);
`ifdef ALU16_OVERFLOW_FLAG_EN
                    if (op_r == OP_ADD) begin
                        rsp_ovf_s = (a_r[W-1] == b_r[W-1]) && (merged_s[W-1] != a_r[W-1]);
                    end else if (op_r == OP_SUB) begin
                        rsp_ovf_s = (a_r[W-1] != b_r[W-1]) && (merged_s[W-1] != a_r[W-1]);
                    end else begin
                        rsp_ovf_s = 1'b0;
                    end
`endif
                end else begin
                    idx_s     = idx_r + IDX_W'(1);
                    drv_en_s  = 1'b1;
                    drv_idx_s = idx_r + IDX_W'(1);
                    drv_cin_s = is_arith(op_r) ? slice_c_out : 1'b0;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Illegal opcodes keep the slice inputs at zero for the whole run.
        if (drv_en_s && (drv_op_s != OP_ILLEGAL)) begin
            slice_a_s   = drv_a_s[NIBBLE_W*drv_idx_s +: NIBBLE_W];
            slice_b_s   = drv_b_s[NIBBLE_W*drv_idx_s +: NIBBLE_W];
            slice_op_s  = drv_op_s;
            slice_cin_s = drv_cin_s;
        end else begin
            slice_a_s   = {NIBBLE_W{1'b0}};
            slice_b_s   = {NIBBLE_W{1'b0}};
            slice_op_s  = 3'b000;
            slice_cin_s = 1'b0;
        end

        req_ready_s = (state_s == IDLE);
        rsp_valid_s = (state_s == DONE);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= {IDX_W{1'b0}};
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            op_r         <= 3'b000;
            result_r     <= {W{1'b0}};
            slice_a_r    <= {NIBBLE_W{1'b0}};
            slice_b_r    <= {NIBBLE_W{1'b0}};
            slice_op_r   <= 3'b000;
            slice_cin_r  <= 1'b0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {W{1'b0}};
            rsp_c_out_r  <= 1'b0;
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
`ifdef ALU16_OVERFLOW_FLAG_EN
            rsp_ovf_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            a_r          <= a_s;
            b_r          <= b_s;
            op_r         <= op_s;
            result_r     <= result_s;
            slice_a_r    <= slice_a_s;
            slice_b_r    <= slice_b_s;
            slice_op_r   <= slice_op_s;
            slice_cin_r  <= slice_cin_s;
            req_ready_r  <= req_ready_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_result_r <= rsp_result_s;
            rsp_c_out_r  <= rsp_c_out_s;
            rsp_zero_r   <= rsp_zero_s;
            rsp_err_r    <= rsp_err_s;
`ifdef ALU16_OVERFLOW_FLAG_EN
            rsp_ovf_r    <= rsp_ovf_s;
`endif
        end
    end

    assign req_ready    = req_ready_r;
    assign slice_a      = slice_a_r;
    assign slice_b      = slice_b_r;
    assign slice_opcode = slice_op_r;
    assign slice_c_in   = slice_cin_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_c_out    = rsp_c_out_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_err      = rsp_err_r;
`ifdef ALU16_OVERFLOW_FLAG_EN
    assign rsp_ovf      = rsp_ovf_r;
`endif

endmodule

// File: tb/tb_alu16_nibble_sequencer.sv
// Self-checking bench: behavioural 4-bit slice, 16-bit reference model and response scoreboard.
module tb_alu16_nibble_sequencer;
    import alu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [2:0]  req_opcode;
    logic [3:0]  slice_a, slice_b, slice_result;
    logic [2:0]  slice_opcode;
    logic        slice_c_in, slice_c_out;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_c_out, rsp_zero, rsp_err;
`ifdef ALU16_OVERFLOW_FLAG_EN
    logic        rsp_ovf;
`endif
    logic [4:0]  sl_sum;

    typedef struct packed {
        logic [15:0] result;
        logic        c_out;
        logic        zero;
        logic        err;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu16_nibble_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .slice_a(slice_a), .slice_b(slice_b), .slice_opcode(slice_opcode),
        .slice_c_in(slice_c_in), .slice_result(slice_result), .slice_c_out(slice_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_c_out(rsp_c_out), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
`ifdef ALU16_OVERFLOW_FLAG_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit ALU slice.
    always_comb begin
        sl_sum = 5'd0;
        case (slice_opcode)
            OP_ADD:  sl_sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_c_in};
            OP_SUB:  sl_sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'd0, slice_c_in};
            OP_AND:  sl_sum = {1'b0, slice_a & slice_b};
            OP_OR:   sl_sum = {1'b0, slice_a | slice_b};
            default: sl_sum = 5'd0;
        endcase
    end
    assign slice_result = sl_sum[3:0];
    assign slice_c_out  = sl_sum[4];

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [16:0] s;
        exp_t        e;
        case (op)
            OP_ADD:  s = {1'b0, a} + {1'b0, b};
            OP_SUB:  s = {1'b0, a} + {1'b0, ~b} + 17'd1;
            OP_AND:  s = {1'b0, a & b};
            OP_OR:   s = {1'b0, a | b};
            default: s = 17'd0;
        endcase
        e.result = s[15:0];
        e.c_out  = (op == OP_ADD || op == OP_SUB) ? s[16] : 1'b0;
        e.zero   = (s[15:0] == 16'd0);
        e.err    = (op == OP_ILLEGAL);
        if (op == OP_ADD)      e.ovf = (a[15] == b[15]) && (s[15] != a[15]);
        else if (op == OP_SUB) e.ovf = (a[15] != b[15]) && (s[15] != a[15]);
        else                   e.ovf = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slice_idle(input string tag);
        chk(tag, {20'd0, slice_a, slice_b, slice_opcode, slice_c_in}, 32'd0);
    endtask

    // Issue one op at the current negedge, wait for the response, hold it for 'stall' cycles, accept it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input int stall, output logic [15:0] got);
        exp_t e;
        int   cyc;
        bit   seen;
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_opcode = op;
        rsp_ready  = (stall == 0);
        sb_q.push_back(model(a, b, op));
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 20) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
                if (op == OP_ILLEGAL) chk_slice_idle({tag, "_slice_idle"});
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_latency"}, cyc, 32'd5);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        for (int s = 0; s <= stall; s++) begin
            chk({tag, "_valid"},  {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_nready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, "_result"}, {16'd0, rsp_result}, {16'd0, e.result});
            chk({tag, "_c_out"},  {31'd0, rsp_c_out}, {31'd0, e.c_out});
            chk({tag, "_zero"},   {31'd0, rsp_zero},  {31'd0, e.zero});
            chk({tag, "_err"},    {31'd0, rsp_err},   {31'd0, e.err});
`ifdef ALU16_OVERFLOW_FLAG_EN
            chk({tag, "_ovf"},    {31'd0, rsp_ovf},   {31'd0, e.ovf});
`endif
            chk_slice_idle({tag, "_slice_done"});
            got = rsp_result;
            if (s == stall) rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_released"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    logic [15:0] got;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = 16'd0;
        req_b      = 16'd0;
        req_opcode = 3'b000;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        chk("rst_flags", {29'd0, rsp_c_out, rsp_zero, rsp_err}, 32'd0);
        chk_slice_idle("rst_slice");

        run_op("add1", 16'h1234, 16'h0FCD, OP_ADD, 0, got);
        chk("add1_const", {16'd0, got}, 32'h2201);
        run_op("add_ripple", 16'hFFFF, 16'h0001, OP_ADD, 0, got);
        chk("add_ripple_const", {16'd0, got}, 32'h0000);
        run_op("sub1", 16'h0005, 16'h0003, OP_SUB, 0, got);
        chk("sub1_const", {16'd0, got}, 32'h0002);
        run_op("sub_ovf", 16'h8000, 16'h0001, OP_SUB, 0, got);
        chk("sub_ovf_const", {16'd0, got}, 32'h7FFF);
        run_op("and1", 16'hF0F0, 16'h3C3C, OP_AND, 0, got);
        chk("and1_const", {16'd0, got}, 32'h3030);
        run_op("illegal", 16'hABCD, 16'h1234, OP_ILLEGAL, 0, got);
        run_op("or1", 16'h1200, 16'h0034, OP_OR, 0, got);
        run_op("zero_op", 16'h1234, 16'h5678, 3'b101, 0, got);
        run_op("add_ovf", 16'h7FFF, 16'h0001, OP_ADD, 0, got);

        run_op("bp", 16'hA5A5, 16'h0F0F, OP_ADD, 3, got);
        run_op("b2b", 16'h4000, 16'h4000, OP_ADD, 0, got);

        // Abort an add while nibble 2 is on the slice.
        req_valid  = 1'b1;
        req_a      = 16'h1111;
        req_b      = 16'h2222;
        req_opcode = OP_ADD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_idx2_a", {28'd0, slice_a}, 32'h1);
        chk("abort_idx2_b", {28'd0, slice_b}, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_result", {16'd0, rsp_result}, 32'd0);
        chk_slice_idle("abort_slice");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        run_op("post_abort", 16'h0F0F, 16'h00F1, OP_ADD, 0, got);
        chk("post_abort_const", {16'd0, got}, 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
